line_buf_ctrl: RTL and testbench

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

---
 rtl/line_buf_pkg.sv | 16 +
 rtl/line_buf_ctrl_edge_det.sv | 24 ++
 rtl/line_buf_ctrl.sv | 142 ++++++++++++++
 tb/tb_line_buf_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buf_pkg.sv
// Shared types and constants for the line-buffer controller.
package line_buf_pkg;

  localparam int ADDR_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } lbc_state_t;

  function automatic logic state_in_frame(input lbc_state_t st);
    return st != ST_IDLE;
  endfunction

endpackage

// File: rtl/line_buf_ctrl_edge_det.sv
// Registered rise/fall detector: compares the live input with its copy from
// the previous cycle. Synchronous active-low reset.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sig_p1 <= 1'b0;
    end else begin
      sig_p1 <= sig;
    end
  end

  assign rise = sig & ~sig_p1;
  assign fall = ~sig & sig_p1;

endmodule

// File: rtl/line_buf_ctrl.sv
// Line-memory write sequencer driven by dv/hs/vs video timing.
// Optional LBC_LEN_CHECK_EN: clamp address at the line width and flag bad line lengths.
module line_buf_ctrl
  import line_buf_pkg::*;
#(
  parameter int SCREENWIDTH = 1600,
  parameter int BUF_DEPTH   = 5,
  parameter int ROW_W       = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dv_i,
  input  logic                 hs_i,
  input  logic                 vs_i,
  output logic [ADDR_W-1:0]    addr_o,
  output logic                 en_o,
  output logic                 we_o,
  output logic [ADDR_W-1:0]    col_o,
  output logic [ROW_W-1:0]     row_o,
  output logic [BUF_DEPTH-1:0] row_valid_o,
  output logic                 frame_start_o,
  output logic                 line_end_o,
  output logic                 len_err_o
);

`ifdef LBC_LEN_CHECK_EN
  localparam int                PIX_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREENWIDTH - 1);
  localparam logic [PIX_W-1:0]  LINE_LEN  = PIX_W'(SCREENWIDTH);
  logic [PIX_W-1:0] pix_cnt;
`else
  localparam int LINE_LEN_UNUSED = SCREENWIDTH;
`endif

  lbc_state_t st;
  logic       in_frame;
  logic       dv_rise;
  logic       dv_fall;
  logic       vs_rise;
  logic       vs_fall_unused;
  logic       hs_unused;

  // Frame start is accepted at either hs_i level, so hs_i never gates sequencing.
  assign hs_unused = hs_i;

  function automatic logic [ROW_W-1:0] row_sat_inc(input logic [ROW_W-1:0] r);
    return (&r) ? r : r + 1'b1;
  endfunction

  edge_det u_dv_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (dv_i),
    .rise (dv_rise),
    .fall (dv_fall)
  );

  edge_det u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (vs_i),
    .rise (vs_rise),
    .fall (vs_fall_unused)
  );

  assign in_frame = state_in_frame(st);
  assign en_o     = in_frame && (dv_i || we_o);

  always_comb begin
    row_valid_o = '0;
    for (int k = 0; k < BUF_DEPTH; k++) begin
      row_valid_o[k] = in_frame && (int'(row_o) >= k);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st            <= ST_IDLE;
      addr_o        <= '0;
      we_o          <= 1'b0;
      col_o         <= '0;
      row_o         <= '0;
      frame_start_o <= 1'b0;
      line_end_o    <= 1'b0;
`ifdef LBC_LEN_CHECK_EN
      pix_cnt       <= '0;
      len_err_o     <= 1'b0;
`endif
    end else begin
      frame_start_o <= vs_rise;
      line_end_o    <= in_frame && dv_fall;
      col_o         <= addr_o;

      // A new frame overrides a line ending in the same cycle.
      if (vs_rise) begin
        row_o <= '0;
      end else if (in_frame && dv_fall) begin
        row_o <= row_sat_inc(row_o);
      end

      if (vs_rise) begin
        st <= ST_BLANK;
      end else begin
        case (st)
          ST_BLANK:  if (dv_rise) st <= ST_ACTIVE;
          ST_ACTIVE: if (dv_fall) st <= ST_BLANK;
          default:   st <= st;
        endcase
      end

      if (!in_frame || !dv_i) begin
        addr_o <= '0;
        we_o   <= 1'b0;
`ifdef LBC_LEN_CHECK_EN
        pix_cnt <= '0;
`endif
      end else begin
`ifdef LBC_LEN_CHECK_EN
        addr_o  <= (addr_o == LAST_ADDR) ? addr_o : addr_o + 1'b1;
        we_o    <= (pix_cnt < LINE_LEN);
        pix_cnt <= (&pix_cnt) ? pix_cnt : pix_cnt + 1'b1;
`else
        addr_o  <= addr_o + 1'b1;
        we_o    <= 1'b1;
`endif
      end

`ifdef LBC_LEN_CHECK_EN
      if (vs_rise) begin
        len_err_o <= 1'b0;
      end else if (in_frame && dv_fall && (pix_cnt != LINE_LEN)) begin
        len_err_o <= 1'b1;
      end
`endif
    end
  end

`ifndef LBC_LEN_CHECK_EN
  assign len_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Scoreboard bench for line_buf_ctrl; expectations come from a line-level model.
module tb_line_buf_ctrl;

  localparam int SW      = 1600;
  localparam int BD      = 5;
  localparam int RW      = 3;
  localparam int AW      = 11;
  localparam int ROW_MAX = (1 << RW) - 1;
`ifdef LBC_LEN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          dv_i, hs_i, vs_i;
  logic [AW-1:0] addr_o, col_o;
  logic          en_o, we_o;
  logic [RW-1:0] row_o;
  logic [BD-1:0] row_valid_o;
  logic          frame_start_o, line_end_o, len_err_o;

  line_buf_ctrl #(.SCREENWIDTH(SW), .BUF_DEPTH(BD), .ROW_W(RW)) dut (
    .clk           (clk),
    .rst           (rst),
    .dv_i          (dv_i),
    .hs_i          (hs_i),
    .vs_i          (vs_i),
    .addr_o        (addr_o),
    .en_o          (en_o),
    .we_o          (we_o),
    .col_o         (col_o),
    .row_o         (row_o),
    .row_valid_o   (row_valid_o),
    .frame_start_o (frame_start_o),
    .line_end_o    (line_end_o),
    .len_err_o     (len_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  typedef struct { int c; int addr; bit we; int col; } en_ev_t;
  typedef struct { int c; bit fs; int row; int rv; bit lerr; } ctl_ev_t;
  en_ev_t  enq[$];
  ctl_ev_t ctq[$];

  // Reference model state: are we inside a frame, lines completed, sticky error.
  bit m_frame = 1'b0;
  int m_row   = 0;
  bit m_lerr  = 1'b0;

  function automatic int f_addr(int p);
    if (CHK) return (p > SW - 1) ? SW - 1 : p;
    return p % (1 << AW);
  endfunction

  function automatic bit f_we(int p);
    return CHK ? (p < SW) : 1'b1;
  endfunction

  function automatic int rv_of(int r);
    int v = 0;
    for (int k = 0; k < BD; k++) if (r >= k) v |= (1 << k);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive3(input bit dv, input bit vs, input bit hs);
    dv_i = dv; vs_i = vs; hs_i = hs;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit dv, input bit vs);
    drive3(dv, vs, 1'($urandom_range(0, 1)));
  endtask

  task automatic push_fs();
    ctq.push_back('{cyc + 1, 1'b1, 0, rv_of(0), 1'b0});
    m_frame = 1'b1; m_row = 0; m_lerr = 1'b0;
  endtask

  task automatic vs_pulse();
    push_fs();
    drive3(0, 1, 1'b1);
    drive3(0, 1, 1'b1);
    drive(0, 0);
    drive(0, 0);
  endtask

  task automatic line(input int n, input bit coinc, input int gap);
    bit was;
    for (int p = 0; p < n; p++) begin
      if (m_frame)
        enq.push_back('{cyc, f_addr(p), (p > 0) ? f_we(p - 1) : 1'b0, (p > 0) ? f_addr(p - 1) : 0});
      drive(1, 0);
    end
    was = m_frame;
    if (m_frame && f_we(n - 1))
      enq.push_back('{cyc, f_addr(n), 1'b1, f_addr(n - 1)});
    if (coinc) begin
      push_fs();
      if (was) ctq.push_back('{cyc + 1, 1'b0, 0, rv_of(0), 1'b0});
    end else if (m_frame) begin
      if (m_row < ROW_MAX) m_row++;
      if (CHK && n != SW) m_lerr = 1'b1;
      ctq.push_back('{cyc + 1, 1'b0, m_row, rv_of(m_row), m_lerr});
    end
    drive(0, coinc);
    for (int g = 1; g < gap; g++) drive(0, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, addr_o, 0);
    chk({tag, "_en"}, en_o, 0);
    chk({tag, "_we"}, we_o, 0);
    chk({tag, "_col"}, col_o, 0);
    chk({tag, "_row"}, row_o, 0);
    chk({tag, "_rv"}, row_valid_o, 0);
    chk({tag, "_fs"}, frame_start_o, 0);
    chk({tag, "_le"}, line_end_o, 0);
    chk({tag, "_lerr"}, len_err_o, 0);
  endtask

  // Monitor: every enabled memory cycle and every pulse must match the next expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (en_o) begin
        checks++;
        if (enq.size() == 0) begin
          failures++;
          $display("FAIL en_unexpected cycle=%0d addr=%0d we=%0d required no enable", cyc, addr_o, we_o);
        end else begin
          en_ev_t e;
          e = enq.pop_front();
          if (e.c != cyc || int'(addr_o) != e.addr || we_o != e.we || (e.we && int'(col_o) != e.col)) begin
            failures++;
            $display("FAIL en_ev actual cyc=%0d addr=%0d we=%0d col=%0d required cyc=%0d addr=%0d we=%0d col=%0d",
                     cyc, addr_o, we_o, col_o, e.c, e.addr, e.we, e.col);
          end
        end
      end
      if (frame_start_o) begin
        checks++;
        if (ctq.size() == 0 || !ctq[0].fs) begin
          failures++;
          $display("FAIL fs_unexpected cycle=%0d row=%0d", cyc, row_o);
        end else begin
          ctl_ev_t e;
          e = ctq.pop_front();
          if (e.c != cyc || int'(row_o) != e.row || int'(row_valid_o) != e.rv || len_err_o != e.lerr) begin
            failures++;
            $display("FAIL fs_ev actual cyc=%0d row=%0d rv=%0d lerr=%0d required cyc=%0d row=%0d rv=%0d lerr=%0d",
                     cyc, row_o, row_valid_o, len_err_o, e.c, e.row, e.rv, e.lerr);
          end
        end
      end
      if (line_end_o) begin
        checks++;
        if (ctq.size() == 0 || ctq[0].fs) begin
          failures++;
          $display("FAIL le_unexpected cycle=%0d row=%0d", cyc, row_o);
        end else begin
          ctl_ev_t e;
          e = ctq.pop_front();
          if (e.c != cyc || int'(row_o) != e.row || int'(row_valid_o) != e.rv || len_err_o != e.lerr) begin
            failures++;
            $display("FAIL le_ev actual cyc=%0d row=%0d rv=%0d lerr=%0d required cyc=%0d row=%0d rv=%0d lerr=%0d",
                     cyc, row_o, row_valid_o, len_err_o, e.c, e.row, e.rv, e.lerr);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b0; dv_i = 1'b0; vs_i = 1'b0; hs_i = 1'b0;
    drive(0, 0);
    mon_en = 1'b1;
    check_zero("init");
    rst = 1'b1;
    drive(0, 0);

    // Pixels before any frame start are ignored.
    line(20, 1'b0, 3);
    chk("idle_rv", row_valid_o, 0);
    chk("idle_row", row_o, 0);

    vs_pulse();
    chk("fs_rv", row_valid_o, 1);
    for (int i = 0; i < 3; i++) line(SW, 1'b0, $urandom_range(1, 4));
    chk("three_rows", row_o, 3);
    chk("three_rv", row_valid_o, 5'b01111);

    line(2050, 1'b0, 2);
    line(1605, 1'b0, 3);
    chk("lerr_after_long", len_err_o, m_lerr);
    for (int i = 0; i < 5; i++) begin
      case ($urandom_range(0, 3))
        0:       n = SW;
        1:       n = $urandom_range(1, 8);
        default: n = $urandom_range(SW - 10, SW + 10);
      endcase
      line(n, 1'b0, $urandom_range(1, 5));
    end
    chk("row_sat", row_o, ROW_MAX);
    chk("rv_sat", row_valid_o, (1 << BD) - 1);
    chk("lerr_sticky", len_err_o, m_lerr);

    vs_pulse();
    chk("lerr_cleared", len_err_o, 0);
    line(SW, 1'b0, 2);
    line(SW, 1'b0, 2);
    chk("pre_coinc_row", row_o, 2);
    line(SW, 1'b1, 3);
    chk("coinc_row", row_o, 0);
    chk("coinc_rv", row_valid_o, 1);
    line(SW, 1'b0, 2);

    // Reset lands on pixel 800 of a line.
    for (int p = 0; p < 800; p++) begin
      enq.push_back('{cyc, f_addr(p), (p > 0) ? f_we(p - 1) : 1'b0, (p > 0) ? f_addr(p - 1) : 0});
      drive(1, 0);
    end
    enq.push_back('{cyc, f_addr(800), f_we(799), f_addr(799)});
    rst = 1'b0;
    drive(1, 0);
    m_frame = 1'b0; m_row = 0; m_lerr = 1'b0;
    check_zero("mid_rst");
    drive(1, 0);
    rst = 1'b1;
    line(50, 1'b0, 3);
    chk("post_rst_rv", row_valid_o, 0);

    vs_pulse();
    line(SW, 1'b0, 3);
    chk("final_row", row_o, 1);
    chk("final_rv", row_valid_o, 5'b00011);

    for (int i = 0; i < 5; i++) drive(0, 0);
    chk("enq_drained", enq.size(), 0);
    chk("ctq_drained", ctq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
